// File: rtl/qos_vc_switch.sv
// qos_vc_switch: ingress words are sorted into NCH virtual-channel queues,
// which a weighted round-robin arbiter drains into per-channel downstream FIFOs.
module qos_vc_switch #(
    parameter int DATA_W   = 12,
    parameter int NCH      = 4,
    parameter int CH_W     = 2,
    parameter int DEPTH    = 8,
    parameter int PTR_W    = 3,
    parameter int WEIGHT_W = 2,
    parameter int CNT_W    = 5
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [PTR_W:0]          umbral_high,
    input  logic [PTR_W:0]          umbral_low,
    input  logic [NCH*WEIGHT_W-1:0] weights,
    input  logic                    push_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [NCH-1:0]          down_afull,
    output logic [DATA_W-1:0]       data_out,
    output logic [NCH-1:0]          push_out,
    output logic [NCH-1:0]          queue_empty,
    output logic [NCH-1:0]          queue_afull,
    output logic [NCH-1:0]          queue_aempty,
    input  logic                    req,
    input  logic [CH_W:0]           idx,
    output logic                    valid,
    output logic [CNT_W-1:0]        data,
    output logic                    active_out,
    output logic                    idle_out
);

    typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;

    localparam logic [PTR_W:0]   LP_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LP_SAT  = '1;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem  [NCH][DEPTH];
    logic [PTR_W-1:0]    r_wp   [NCH];
    logic [PTR_W-1:0]    r_rp   [NCH];
    logic [PTR_W:0]      r_cnt  [NCH];
    logic [WEIGHT_W-1:0] r_wt   [NCH];
    logic [CNT_W-1:0]    r_stat [NCH+1];
    logic [PTR_W:0]      r_hi;
    logic [PTR_W:0]      r_lo;
    logic [CH_W-1:0]     r_ptr;
    logic [WEIGHT_W-1:0] r_cred;
    logic [DATA_W-1:0]   r_dout;
    logic [NCH-1:0]      r_pout;
    logic                r_valid;
    logic [CNT_W-1:0]    r_data;

    logic                w_run;
    logic [CH_W-1:0]     w_ch;
    logic                w_full;
    logic                w_wr;
    logic                w_drop;
    logic [NCH-1:0]      w_empty;
    logic [NCH-1:0]      w_elig;
    logic [NCH-1:0]      w_push;
    logic [NCH-1:0]      w_pop;
    logic                w_gnt;
    logic [CH_W-1:0]     w_gch;
    logic [CH_W-1:0]     w_nptr;
    logic [WEIGHT_W-1:0] w_ncred;
    logic [CNT_W-1:0]    w_sel;

    assign w_run  = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    assign w_ch   = data_in[DATA_W-1 -: CH_W];
    assign w_full = (r_cnt[w_ch] == LP_FULL);
    assign w_wr   = w_run && push_in && !w_full;
    assign w_drop = w_run && push_in && w_full;

    // A zero high threshold leaves almost-full deasserted.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_empty[i]      = (r_cnt[i] == '0);
            w_elig[i]       = !w_empty[i] && !down_afull[i];
            w_push[i]       = w_wr && (w_ch == CH_W'(i));
            w_pop[i]        = w_gnt && (w_gch == CH_W'(i));
            queue_afull[i]  = (r_hi != '0) && (r_cnt[i] >= r_hi);
            queue_aempty[i] = (r_cnt[i] <= r_lo);
        end
    end

    always_comb begin
        logic [CH_W-1:0] c;
        c       = r_ptr;
        w_gnt   = 1'b0;
        w_gch   = r_ptr;
        w_nptr  = r_ptr;
        w_ncred = r_cred;
        if (r_state == S_ACTIVE) begin
            if (w_elig[r_ptr] && (r_cred != '0)) begin
                w_gnt   = 1'b1;
                w_ncred = r_cred - 1'b1;
            end else begin
                for (int k = 1; k <= NCH; k++) begin
                    c = r_ptr + CH_W'(k);
                    if (!w_gnt && w_elig[c]) begin
                        w_gnt   = 1'b1;
                        w_gch   = c;
                        w_nptr  = c;
                        w_ncred = r_wt[c];
                    end
                end
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k <= NCH; k++) begin
            if (idx == (CH_W+1)'(k)) w_sel = r_stat[k];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_ch][r_wp[w_ch]] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_RESET;
            r_hi    <= '0;
            r_lo    <= '0;
            r_ptr   <= '0;
            r_cred  <= '0;
            r_dout  <= '0;
            r_pout  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
                r_wt[i]  <= '0;
            end
            for (int k = 0; k <= NCH; k++) r_stat[k] <= '0;
        end else begin
            case (r_state)
                S_RESET:  r_state <= S_INIT;
                S_INIT:   if (!init) r_state <= S_IDLE;
                S_IDLE: begin
                    if (init)         r_state <= S_INIT;
                    else if (!(&w_empty)) r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (init) r_state <= S_INIT;
                    else if ((&w_empty) && (r_pout == '0)) r_state <= S_IDLE;
                end
                default:  r_state <= S_RESET;
            endcase

            if (r_state == S_INIT) begin
                r_hi <= umbral_high;
                r_lo <= umbral_low;
                for (int i = 0; i < NCH; i++)
                    r_wt[i] <= weights[i*WEIGHT_W +: WEIGHT_W];
            end

            for (int i = 0; i < NCH; i++) begin
                if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i])  r_rp[i] <= r_rp[i] + 1'b1;
                if (w_push[i] && !w_pop[i])
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!w_push[i] && w_pop[i])
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end

            r_ptr  <= w_nptr;
            r_cred <= w_ncred;
            if (w_gnt) begin
                r_dout <= r_mem[w_gch][r_rp[w_gch]];
                r_pout <= NCH'(1) << w_gch;
            end else begin
                r_pout <= '0;
            end

            // Index NCH of the statistics array is the drop counter.
            if (r_state == S_INIT) begin
                for (int k = 0; k <= NCH; k++) r_stat[k] <= '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (r_pout[i] && (r_stat[i] != LP_SAT))
                        r_stat[i] <= r_stat[i] + 1'b1;
                end
                if (w_drop && (r_stat[NCH] != LP_SAT))
                    r_stat[NCH] <= r_stat[NCH] + 1'b1;
            end

            r_valid <= req;
            r_data  <= req ? w_sel : '0;
        end
    end

    assign data_out    = r_dout;
    assign push_out    = r_pout;
    assign queue_empty = w_empty;
    assign valid       = r_valid;
    assign data        = r_data;
    assign active_out  = (r_state == S_ACTIVE);
    assign idle_out    = (r_state == S_IDLE);

endmodule
